// File: rtl/trap_ctrl_if.sv
// Bus bundle between the write-back stage, the CSR file and fetch, and the trap sequencer.
// The WB/CSR side drives it through "master"; trap_ctrl uses the "slave" modport.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     instruction_i;
  logic [XLEN-1:0] fault_addr_i;
  logic            e_inst_addr_mis_i;
  logic            e_illegal_inst_i;
  logic            e_ld_addr_mis_i;
  logic            e_st_addr_mis_i;
  logic            is_mret_i;
  logic            xint_meip_i;
  logic            xint_mtip_i;
  logic            xint_msip_i;
  logic [XLEN-1:0] mie_i;
  logic            mstatus_mie_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;

  logic            trap_we_o;
  logic [XLEN-1:0] mcause_o;
  logic [XLEN-1:0] mepc_o;
  logic [XLEN-1:0] mtval_o;
  logic            mret_o;
  logic            flush_o;
  logic            redirect_o;
  logic [XLEN-1:0] target_o;
  logic            busy_o;

  modport master (
    output valid_i, pc_i, instruction_i, fault_addr_i,
           e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i,
           is_mret_i, xint_meip_i, xint_mtip_i, xint_msip_i,
           mie_i, mstatus_mie_i, mtvec_i, mepc_i,
    input  trap_we_o, mcause_o, mepc_o, mtval_o, mret_o,
           flush_o, redirect_o, target_o, busy_o
  );

  modport slave (
    input  valid_i, pc_i, instruction_i, fault_addr_i,
           e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i,
           is_mret_i, xint_meip_i, xint_mtip_i, xint_msip_i,
           mie_i, mstatus_mie_i, mtvec_i, mepc_i,
    output trap_we_o, mcause_o, mepc_o, mtval_o, mret_o,
           flush_o, redirect_o, target_o, busy_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer for WB: prioritises interrupts/exceptions, writes trap CSRs, flushes and redirects.
// Optional macro TRAP_VECTORED_EN: vectored interrupt targets when mtvec.MODE==1.
module trap_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 3
) (
  input logic        clk_i,
  input logic        rst_i,
  trap_ctrl_if.slave bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, TRAP, MRET, REDIR, DRAIN} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            trap_we_q, mret_q, flush_q, redirect_q, busy_q;
  logic [XLEN-1:0] mcause_q, mepc_q, mtval_q, target_q;

  logic            int_en, mei, msi, mti, take, is_int, mret_take;
  logic [3:0]      code;
  logic [XLEN-1:0] tval_d, mcause_d, base, vec_tgt;

  // Interrupts outrank every exception; within each group the fixed order below applies.
  always_comb begin
    int_en = bus.valid_i & bus.mstatus_mie_i;
    mei    = int_en & bus.xint_meip_i & bus.mie_i[11];
    msi    = int_en & bus.xint_msip_i & bus.mie_i[3];
    mti    = int_en & bus.xint_mtip_i & bus.mie_i[7];
    take   = 1'b1;
    is_int = 1'b0;
    code   = 4'd0;
    tval_d = '0;
    if (mei) begin
      is_int = 1'b1; code = 4'd11;
    end else if (msi) begin
      is_int = 1'b1; code = 4'd3;
    end else if (mti) begin
      is_int = 1'b1; code = 4'd7;
    end else if (bus.valid_i && bus.e_inst_addr_mis_i) begin
      code = 4'd0; tval_d = bus.fault_addr_i;
    end else if (bus.valid_i && bus.e_illegal_inst_i) begin
      code = 4'd2; tval_d = XLEN'(bus.instruction_i);
    end else if (bus.valid_i && bus.e_ld_addr_mis_i) begin
      code = 4'd4; tval_d = bus.fault_addr_i;
    end else if (bus.valid_i && bus.e_st_addr_mis_i) begin
      code = 4'd6; tval_d = bus.fault_addr_i;
    end else begin
      take = 1'b0;
    end
    mret_take = bus.valid_i & bus.is_mret_i & ~take;
    mcause_d  = {is_int, {(XLEN-5){1'b0}}, code};
  end

  // Vector target is formed from the latched cause one cycle after the trap was taken.
  always_comb begin
    base = {bus.mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (bus.mtvec_i[1:0] == 2'b01 && mcause_q[XLEN-1])
      vec_tgt = base + (XLEN'(mcause_q[3:0]) << 2);
    else
      vec_tgt = base;
`else
    vec_tgt = base;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trap_we_q  <= 1'b0;
      mret_q     <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      busy_q     <= 1'b0;
      mcause_q   <= '0;
      mepc_q     <= '0;
      mtval_q    <= '0;
      target_q   <= '0;
    end else begin
      trap_we_q  <= 1'b0;
      mret_q     <= 1'b0;
      redirect_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q   <= TRAP;
            trap_we_q <= 1'b1;
            flush_q   <= 1'b1;
            busy_q    <= 1'b1;
            mcause_q  <= mcause_d;
            mepc_q    <= bus.pc_i;
            mtval_q   <= tval_d;
          end else if (mret_take) begin
            state_q <= MRET;
            mret_q  <= 1'b1;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TRAP: begin
          state_q    <= REDIR;
          redirect_q <= 1'b1;
          target_q   <= vec_tgt;
        end
        MRET: begin
          state_q    <= REDIR;
          redirect_q <= 1'b1;
          target_q   <= bus.mepc_i;
        end
        REDIR: begin
          state_q <= DRAIN;
          cnt_q   <= CW'(FLUSH_CYCLES - 1);
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trap_we_o  = trap_we_q;
  assign bus.mcause_o   = mcause_q;
  assign bus.mepc_o     = mepc_q;
  assign bus.mtval_o    = mtval_q;
  assign bus.mret_o     = mret_q;
  assign bus.flush_o    = flush_q;
  assign bus.redirect_o = redirect_q;
  assign bus.target_o   = target_q;
  assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap/MRET sequencing, priorities, drain timing, reset abort.
module tb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.valid_i = 0; bus.pc_i = '0; bus.instruction_i = '0; bus.fault_addr_i = '0;
    bus.e_inst_addr_mis_i = 0; bus.e_illegal_inst_i = 0;
    bus.e_ld_addr_mis_i = 0; bus.e_st_addr_mis_i = 0; bus.is_mret_i = 0;
    bus.xint_meip_i = 0; bus.xint_mtip_i = 0; bus.xint_msip_i = 0;
    bus.mie_i = '0; bus.mstatus_mie_i = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    clr_in();
    bus.mtvec_i = 32'h80;
    bus.mepc_i  = '0;
    tick(); tick();
    // reset state
    chk("rst_busy",   {31'd0, bus.busy_o},     32'd0);
    chk("rst_flush",  {31'd0, bus.flush_o},    32'd0);
    chk("rst_we",     {31'd0, bus.trap_we_o},  32'd0);
    chk("rst_mcause", bus.mcause_o,            32'd0);
    chk("rst_target", bus.target_o,            32'd0);
    rst = 1'b0;

    // 1: illegal instruction, then check drain timing with junk during busy
    bus.valid_i = 1; bus.e_illegal_inst_i = 1; bus.pc_i = 32'h100;
    bus.instruction_i = 32'hFFFF_FFFF;
    tick();                                   // T+1
    chk("t1_we",     {31'd0, bus.trap_we_o},  32'd1);
    chk("t1_flush",  {31'd0, bus.flush_o},    32'd1);
    chk("t1_mcause", bus.mcause_o,            32'd2);
    chk("t1_mtval",  bus.mtval_o,             32'hFFFF_FFFF);
    chk("t1_mepc",   bus.mepc_o,              32'h100);
    chk("t1_redir0", {31'd0, bus.redirect_o}, 32'd0);
    tick();                                   // T+2
    chk("t1_redir",  {31'd0, bus.redirect_o}, 32'd1);
    chk("t1_target", bus.target_o,            32'h80);
    chk("t1_we_off", {31'd0, bus.trap_we_o},  32'd0);
    for (int i = 0; i < FC; i++) begin        // T+3 .. T+2+FC, inputs still asserted
      tick();
      chk("t1_drain_busy", {31'd0, bus.busy_o},    32'd1);
      chk("t1_drain_we",   {31'd0, bus.trap_we_o}, 32'd0);
    end
    clr_in();
    tick();                                   // T+3+FC
    chk("t1_idle_busy",  {31'd0, bus.busy_o},  32'd0);
    chk("t1_idle_flush", {31'd0, bus.flush_o}, 32'd0);
    chk("t1_hold",       bus.mcause_o,         32'd2);
    // invalid instruction must not trap
    bus.e_illegal_inst_i = 1;
    tick();
    chk("nv_we", {31'd0, bus.trap_we_o}, 32'd0);
    clr_in();

    // 2: timer interrupt, enabled then globally masked
    bus.valid_i = 1; bus.xint_mtip_i = 1; bus.mie_i = 32'h80;
    bus.mstatus_mie_i = 1; bus.pc_i = 32'h200;
    tick();
    chk("t2_we",     {31'd0, bus.trap_we_o}, 32'd1);
    chk("t2_mcause", bus.mcause_o,           32'h8000_0007);
    chk("t2_mtval",  bus.mtval_o,            32'd0);
    chk("t2_mepc",   bus.mepc_o,             32'h200);
    clr_in();
    wait_idle("t2_idle");
    bus.valid_i = 1; bus.xint_mtip_i = 1; bus.mie_i = 32'h80; bus.mstatus_mie_i = 0;
    tick();
    chk("t2_masked_we", {31'd0, bus.trap_we_o}, 32'd0);
    chk("t2_masked_bz", {31'd0, bus.busy_o},    32'd0);
    chk("t2_hold",      bus.mcause_o,           32'h8000_0007);
    clr_in();

    // 3: all interrupts plus illegal -> MEI wins
    bus.valid_i = 1; bus.xint_meip_i = 1; bus.xint_msip_i = 1; bus.xint_mtip_i = 1;
    bus.e_illegal_inst_i = 1; bus.instruction_i = 32'h1234_5678;
    bus.mie_i = 32'h888; bus.mstatus_mie_i = 1; bus.pc_i = 32'h300;
    tick();
    chk("t3_mcause", bus.mcause_o, 32'h8000_000B);
    chk("t3_mtval",  bus.mtval_o,  32'd0);
    chk("t3_mepc",   bus.mepc_o,   32'h300);
    clr_in();
    wait_idle("t3_idle");
    // MSI over MTI
    bus.valid_i = 1; bus.xint_msip_i = 1; bus.xint_mtip_i = 1;
    bus.mie_i = 32'h88; bus.mstatus_mie_i = 1;
    tick();
    chk("t3_msi", bus.mcause_o, 32'h8000_0003);
    clr_in();
    wait_idle("t3b_idle");

    // 4: ld+st misaligned with MRET -> load wins, no mret
    bus.valid_i = 1; bus.e_ld_addr_mis_i = 1; bus.e_st_addr_mis_i = 1; bus.is_mret_i = 1;
    bus.fault_addr_i = 32'h1003; bus.pc_i = 32'h400;
    tick();
    chk("t4_we",     {31'd0, bus.trap_we_o}, 32'd1);
    chk("t4_mcause", bus.mcause_o,           32'd4);
    chk("t4_mtval",  bus.mtval_o,            32'h1003);
    chk("t4_mret",   {31'd0, bus.mret_o},    32'd0);
    clr_in();
    tick();
    chk("t4_mret2",  {31'd0, bus.mret_o},    32'd0);
    wait_idle("t4_idle");
    // inst misaligned over illegal
    bus.valid_i = 1; bus.e_inst_addr_mis_i = 1; bus.e_illegal_inst_i = 1;
    bus.fault_addr_i = 32'h502;
    tick();
    chk("t4_iam_cause", bus.mcause_o, 32'd0);
    chk("t4_iam_tval",  bus.mtval_o,  32'h502);
    clr_in();
    wait_idle("t4b_idle");

    // 5: MRET
    bus.valid_i = 1; bus.is_mret_i = 1; bus.mepc_i = 32'h344;
    tick();
    chk("t5_mret",  {31'd0, bus.mret_o},    32'd1);
    chk("t5_flush", {31'd0, bus.flush_o},   32'd1);
    chk("t5_we",    {31'd0, bus.trap_we_o}, 32'd0);
    clr_in();
    tick();
    chk("t5_mret_off", {31'd0, bus.mret_o},     32'd0);
    chk("t5_redir",    {31'd0, bus.redirect_o}, 32'd1);
    chk("t5_target",   bus.target_o,            32'h344);
    wait_idle("t5_idle");

    // 6: vectored mtvec, then reset during drain
    bus.mtvec_i = 32'h81;
    bus.valid_i = 1; bus.xint_mtip_i = 1; bus.mie_i = 32'h80; bus.mstatus_mie_i = 1;
    bus.pc_i = 32'h600;
    tick();
    chk("t6_mcause", bus.mcause_o, 32'h8000_0007);
    clr_in();
    tick();
`ifdef TRAP_VECTORED_EN
    chk("t6_target", bus.target_o, 32'h9C);
`else
    chk("t6_target", bus.target_o, 32'h80);
`endif
    tick();                                   // first DRAIN cycle
    chk("t6_drain_busy", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_busy",   {31'd0, bus.busy_o},     32'd0);
    chk("t6_rst_flush",  {31'd0, bus.flush_o},    32'd0);
    chk("t6_rst_target", bus.target_o,            32'd0);
    chk("t6_rst_mcause", bus.mcause_o,            32'd0);
    chk("t6_rst_mepc",   bus.mepc_o,              32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_busy",  {31'd0, bus.busy_o},     32'd0);
    chk("t6_post_redir", {31'd0, bus.redirect_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
